// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
//
// Pops bytes from a show-ahead FIFO and serialises them as 8N1 UART frames
// (one start bit, eight data bits LSB first, one stop bit). Each serial bit is
// held for CLKS_PER_BIT clock cycles.
//
// Ports
//   clk          : single clock, all state changes on its rising edge
//   rst          : synchronous active-low reset
//   tx_en        : transmit enable; when low no new frame is started
//   empty        : FIFO empty flag
//   rdata[7:0]   : FIFO read data, valid whenever empty is low
//   rd           : one-cycle FIFO pop strobe (combinational, IDLE only)
//   tx           : registered serial line, idles high
//   busy         : high whenever the state machine is not in IDLE
//   tx_done      : one-cycle pulse in the last cycle of the stop bit
//   state_dbg_o  : current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Handshake: the FIFO is show-ahead, so a byte is consumed in the same cycle
// that rd is high; rdata is captured into the shift register at that edge and
// the start bit appears on tx from the very next cycle.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en,
  input  logic       empty,
  input  logic [7:0] rdata,
  output logic       rd,
  output logic       tx,
  output logic       busy,
  output logic       tx_done,
  output logic [1:0] state_dbg_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Counter only has to reach CLKS_PER_BIT-1.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PENULT  = CW'(CLKS_PER_BIT - 2);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic          tx_q;
  logic          tx_done_q;

  logic          pop;
  logic          bit_end;

  // Pop is gated by reset so that no byte is consumed in a reset cycle.
  assign pop     = rst && (state_q == IDLE) && tx_en && !empty;
  assign bit_end = (cnt_q == CNT_LAST);

  assign rd          = pop;
  assign tx          = tx_q;
  assign busy        = (state_q != IDLE);
  assign tx_done     = tx_done_q;
  assign state_dbg_o = state_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q      <= 1'b1;
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (pop) begin
            shreg_q <= rdata;
            tx_q    <= 1'b0;          // start bit begins next cycle
            state_q <= START;
          end
        end

        START: begin
          if (bit_end) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            tx_q      <= shreg_q[0];
            state_q   <= DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;        // stop bit
              state_q <= STOP;
            end else begin
              // Present the next bit from the pre-shift value so tx stays
              // a pure register with no combinational path.
              tx_q      <= shreg_q[1];
              shreg_q   <= shreg_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
            // Registered pulse lands on the final stop-bit cycle.
            if (cnt_q == CNT_PENULT) begin
              tx_done_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          cnt_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10417, SHALL set the clock cycles per serial bit (100 MHz / 9600 baud); legal range 2..65535.
REQ-002 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 tx_en  input  1  SHALL be the transmit enable; when low, no new frame starts.
REQ-005 empty  input  1  SHALL be the FIFO empty flag.
REQ-006 rdata  input  8  SHALL be the FIFO read data, valid combinationally whenever empty is low.
REQ-007 rd  output  1  SHALL be the one-cycle FIFO pop strobe.
REQ-008 tx  output  1  SHALL be the serial line, idle high.
REQ-009 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-010 tx_done  output  1  SHALL be a one-cycle pulse marking frame completion.

Function
REQ-011 The block SHALL implement states IDLE, START, DATA and STOP, encoded as a registered state machine.
REQ-012 IDLE: when tx_en=1 and empty=0, the block SHALL assert rd combinationally in that cycle, capture rdata into an 8-bit shift register at the same edge, and transition to START.
REQ-013 rd SHALL never be asserted outside IDLE, never when empty=1, and never for more than one consecutive cycle.
REQ-014 START: tx=0 for exactly CLKS_PER_BIT cycles, then transition to DATA with bit index 0.
REQ-015 DATA: tx SHALL equal the shift register LSB, and each bit SHALL be held exactly CLKS_PER_BIT cycles, LSB first.
REQ-016 DATA: after the bit with index 7 completes, the block SHALL transition to STOP.
REQ-017 STOP: tx=1 for exactly CLKS_PER_BIT cycles; in the final cycle tx_done=1, and the next state is IDLE.
REQ-018 Frame length SHALL be 10*CLKS_PER_BIT cycles from the first START cycle through the last STOP cycle.
REQ-019 tx SHALL be registered (glitch-free), and the first START-level cycle SHALL be the cycle after the rd strobe.
REQ-020 Back-to-back frames: the block SHALL spend exactly one cycle in IDLE between frames when the FIFO is non-empty, giving a pop-to-pop spacing of 10*CLKS_PER_BIT+1 cycles.
REQ-021 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reset to 0 at every bit boundary, with no cumulative drift.
REQ-022 Deasserting tx_en mid-frame SHALL NOT abort the frame; it SHALL only inhibit the next pop.
REQ-023 Changes on empty or rdata while not in IDLE SHALL NOT affect the frame in progress.
REQ-024 The 3-bit bit index SHALL wrap only by the state transition, with no ninth data bit.

Reset
REQ-025 While rst=0 at a rising edge, the block SHALL set state=IDLE, tx=1, rd=0, busy=0, tx_done=0, and clear the counters and shift register.
REQ-026 Reset asserted mid-frame SHALL abort the frame at the next edge, with tx=1 from that edge; the byte already popped SHALL be lost and no extra pop SHALL occur.
REQ-027 After rst returns high, a pop SHALL be possible at the first IDLE cycle.

Verification (CLKS_PER_BIT=4)
REQ-028 Single byte: empty=0, rdata=8'hA5, tx_en=1 -> one rd pulse; tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tx_done pulse at cycle 40 after rd; busy high 40 cycles.
REQ-029 Back-to-back: FIFO holds 8'h00 then 8'hFF -> rd pulses 41 cycles apart; second frame is 0,1×8,1; exactly 2 rd pulses, then empty=1 keeps IDLE with tx=1.
REQ-030 Empty/disabled: empty=1 with tx_en=1, or empty=0 with tx_en=0, for 100 cycles -> rd=0, tx=1, busy=0 throughout.
REQ-031 tx_en drop: tx_en falls in the DATA state of 8'h3C -> frame completes correctly; no further rd until tx_en returns high.
REQ-032 Mid-frame reset: rst=0 for 1 cycle during DATA bit 3 -> next edge tx=1, busy=0; no rd in the reset cycle; the next byte transmits cleanly after release.
REQ-033 Integration with the 8-deep FIFO: write 8 bytes 8'h01..8'h08 -> serial output in order, full deasserts after the first pop, empty asserts after the eighth pop.
